// File: rtl/if_pc_stage_if.sv
// Fetch-stage bus: next-PC selector / IM / hazard control on one side,
// the IF stage (PC + IF/ID register) on the other.
// Optional IF_FETCH_CNT_EN adds the fetch_cnt observation signal.
interface if_pc_stage_if;
  logic [31:0] next_pc;
  logic        stall;
  logic        int_req;
  logic        flush_d;
  logic        is_branch_d;
  logic [31:0] instr_f;
  logic [31:0] pc_f;
  logic [31:0] pc4_f;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc8_d;
  logic        bd_d;
  logic        exc_valid_d;
  logic [4:0]  exc_code_d;
`ifdef IF_FETCH_CNT_EN
  logic [31:0] fetch_cnt;

  modport master (
    output next_pc, stall, int_req, flush_d, is_branch_d, instr_f,
    input  pc_f, pc4_f, instr_d, pc_d, pc8_d, bd_d, exc_valid_d, exc_code_d,
    input  fetch_cnt
  );

  modport slave (
    input  next_pc, stall, int_req, flush_d, is_branch_d, instr_f,
    output pc_f, pc4_f, instr_d, pc_d, pc8_d, bd_d, exc_valid_d, exc_code_d,
    output fetch_cnt
  );
`else
  modport master (
    output next_pc, stall, int_req, flush_d, is_branch_d, instr_f,
    input  pc_f, pc4_f, instr_d, pc_d, pc8_d, bd_d, exc_valid_d, exc_code_d
  );

  modport slave (
    input  next_pc, stall, int_req, flush_d, is_branch_d, instr_f,
    output pc_f, pc4_f, instr_d, pc_d, pc8_d, bd_d, exc_valid_d, exc_code_d
  );
`endif
endinterface

// File: rtl/if_pc_stage.sv
// Fetch stage: program counter, IF/ID pipeline register, fetch address
// (AdEL) detection and branch-delay-slot tagging for the CP0 path.
// Optional feature macro IF_FETCH_CNT_EN: counts clean IF/ID loads.
module if_pc_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IM_BASE    = 32'h0000_3000,
  parameter logic [31:0] IM_LIMIT   = 32'h0000_6FFC
) (
  input  logic          clk,
  input  logic          reset,
  if_pc_stage_if.slave  bus
);

  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] pc_d_q;
  logic        bd_q;
  logic        exc_valid_q;
  logic [4:0]  exc_code_q;
  logic        fetch_exc;
  logic        id_load;

  // Misaligned or out-of-IM fetch address raises AdEL
  always_comb begin
    fetch_exc = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || (pc_q > IM_LIMIT);
    id_load   = !bus.int_req && !bus.flush_d && !bus.stall;
  end

  // PC register: redirect beats stall, stall beats next_pc
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else if (bus.int_req) begin
      pc_q <= HANDLER_PC;
    end else if (!bus.stall) begin
      pc_q <= bus.next_pc;
    end
  end

  // IF/ID register: bubble on redirect/flush, hold on stall, else load
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q     <= '0;
      pc_d_q      <= '0;
      bd_q        <= 1'b0;
      exc_valid_q <= 1'b0;
      exc_code_q  <= '0;
    end else if (bus.int_req || bus.flush_d) begin
      instr_q     <= '0;
      pc_d_q      <= '0;
      bd_q        <= 1'b0;
      exc_valid_q <= 1'b0;
      exc_code_q  <= '0;
    end else if (!bus.stall) begin
      // Faulting fetch becomes a nop but keeps its PC for EPC/BadVAddr
      instr_q     <= fetch_exc ? '0 : bus.instr_f;
      pc_d_q      <= pc_q;
      bd_q        <= bus.is_branch_d;
      exc_valid_q <= fetch_exc;
      exc_code_q  <= fetch_exc ? 5'd4 : '0;
    end
  end

`ifdef IF_FETCH_CNT_EN
  logic [31:0] fetch_cnt_q;

  // Count IF/ID loads of exception-free instructions
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt_q <= '0;
    end else if (id_load && !fetch_exc) begin
      fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end
  end

  assign bus.fetch_cnt = fetch_cnt_q;
`else
  logic unused_id_load;
  assign unused_id_load = id_load;
`endif

  assign bus.pc_f        = pc_q;
  assign bus.pc4_f       = pc_q + 32'd4;
  assign bus.instr_d     = instr_q;
  assign bus.pc_d        = pc_d_q;
  assign bus.pc8_d       = pc_d_q + 32'd8;
  assign bus.bd_d        = bd_q;
  assign bus.exc_valid_d = exc_valid_q;
  assign bus.exc_code_d  = exc_code_q;

endmodule

// File: doc/if_pc_stage.md
Name: if_pc_stage

Overview:
- Fetch-stage block: holds the program counter and the IF/ID pipeline register.
- Consumes next_pc produced by the next-PC selector and drives pc_f/pc4_f back to it and to the instruction memory.
- Detects fetch address exceptions (AdEL) and tags each instruction with its delay-slot status for the CP0 exception path.

Parameters:
RESET_PC, 32'h0000_3000, PC value after reset
HANDLER_PC, 32'h0000_4180, exception/interrupt entry address
IM_BASE, 32'h0000_3000, lowest legal fetch address
IM_LIMIT, 32'h0000_6FFC, highest legal fetch address (inclusive)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
next_pc  in  32  candidate next PC from next-PC selector
stall  in  1  hazard stall: hold PC and IF/ID
int_req  in  1  exception/interrupt taken this cycle (redirect + flush)
flush_d  in  1  clear IF/ID (eret squash) without redirecting PC
is_branch_d  in  1  instruction currently in D is a branch/jump
instr_f  in  32  instruction word read from IM at pc_f
pc_f  out  32  current fetch PC
pc4_f  out  32  pc_f + 4
instr_d  out  32  registered instruction for D
pc_d  out  32  registered PC for D
pc8_d  out  32  pc_d + 8 (link address)
bd_d  out  1  D instruction sits in a branch delay slot
exc_valid_d  out  1  D instruction carries a fetch exception
exc_code_d  out  5  exception code for D (4 = AdEL, else 0)

Behaviour:
- Reset (reset == 0, asynchronous): pc_f = RESET_PC; instr_d = 0; pc_d = 0; bd_d = 0; exc_valid_d = 0; exc_code_d = 0.
- PC register update, at each rising clk, in priority order:
  - int_req: pc_f <= HANDLER_PC. Overrides stall.
  - stall: hold.
  - else: pc_f <= next_pc.
- pc4_f and pc8_d are combinational. Arithmetic is 32-bit and wraps modulo 2^32 with no carry-out.
- Fetch exception is combinational on pc_f. It is raised when any of these holds:
  - pc_f[1:0] != 0
  - pc_f < IM_BASE
  - pc_f > IM_LIMIT
- On a fetch exception the word latched into instr_d is forced to 32'h0 (nop), exc_code = 5'd4, exc_valid = 1. pc_d still latches the offending pc_f so it can become EPC/BadVAddr.
- IF/ID update, at each rising clk, in priority order:
  - int_req or flush_d: bubble. instr_d = 0, pc_d = 0, bd_d = 0, exc_valid_d = 0, exc_code_d = 0.
  - stall: hold all D outputs.
  - else: load instr (or nop), pc_f, bd_d <= is_branch_d, plus the exception tag.
- Simultaneous events:
  - int_req + stall: PC redirects and D is bubbled.
  - flush_d + stall: D is bubbled and PC holds.
  - int_req + flush_d: same as int_req alone.
- Latency:
  - next_pc appears on pc_f one cycle after presentation.
  - An instruction fetched at pc_f appears on instr_d one cycle later (no stall).
- Reset asserted mid-stall or mid-redirect: all state returns to reset values immediately, independent of clk.
- No internal memory of a pending redirect. A stall never delays or loses int_req.

Optional Feature:
- Macro: IF_FETCH_CNT_EN.
- Defined:
  - Adds output port fetch_cnt [31:0], reset to 0.
  - Increments by 1, wrapping modulo 2^32, on each clock edge where IF/ID loads (no int_req, no flush_d, no stall) with no fetch exception.
- Not defined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset release then next_pc = pc4_f for 3 cycles -> pc_f sequence 0x3000, 0x3004, 0x3008, 0x300C; instr_d follows one cycle behind with pc_d = 0x3000, 0x3004, 0x3008.
- stall = 1 for 2 cycles at pc_f = 0x3010 -> pc_f and all D outputs hold; on release pc_f = next_pc (0x3014) next edge.
- int_req = 1 together with stall = 1 at pc_f = 0x3020 -> next edge pc_f = 0x4180, instr_d = 0, pc_d = 0, bd_d = 0, exc_valid_d = 0.
- next_pc = 0x3002, then 0x2FFC, then 0x7000 -> each fetch gives exc_valid_d = 1, exc_code_d = 4, instr_d = 0, pc_d equal to the bad address.
- is_branch_d = 1 while instr at 0x3040 is fetched -> D shows pc_d = 0x3040 with bd_d = 1 and pc8_d = 0x3048. flush_d on the following edge zeroes instr_d and bd_d.
- With IF_FETCH_CNT_EN: 5 normal loads, 1 stall, 1 AdEL fetch, 1 flush -> fetch_cnt = 5. Asserting reset mid-sequence returns it to 0 immediately.
